uart_tx_fifo: RTL and testbench

Byte FIFO and launch controller that sits directly upstream of the UART transmitter.
Producers write bytes at clk rate. The block drains them one at a time into the UART's transmit/data_tx/busy_tx handshake, so a host can queue a message without waiting on each 115200-baud byte time.
Status outputs report fill level, full/empty and dropped writes.

---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: queues bytes at clk rate and launches them one at a
// time through the transmit/data_tx/busy_tx handshake.
module uart_tx_fifo #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   input  logic              busy_tx,
   output logic              transmit,
   output logic [7:0]        data_tx,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              active
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWaitBusy,
      StWaitDone
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          mem_q [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                full_q, full_d;
   logic                empty_q, empty_d;
   logic                overflow_q, overflow_d;
   logic                transmit_q, transmit_d;
   logic [7:0]          data_tx_q, data_tx_d;
   logic                active_q, active_d;
   logic                push, pop;

   // Full is judged on the registered (pre-edge) count, so a same-cycle pop never rescues a write.
   always_comb begin
      push       = wr_en && !flush && !full_q;
      pop        = (state_q == StIdle) && !empty_q && !busy_tx && !flush;
      overflow_d = wr_en && full_q && !flush;

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
         endcase
      end
      full_d  = (count_d == FullCount);
      empty_d = (count_d == '0);
   end

   // Launch controller; flush leaves it alone so an in-flight byte always completes.
   always_comb begin
      state_d    = state_q;
      transmit_d = transmit_q;
      data_tx_d  = data_tx_q;
      active_d   = active_q;
      case (state_q)
         StIdle: begin
            if (pop) begin
               data_tx_d  = mem_q[rd_ptr_q];
               transmit_d = 1'b1;
               active_d   = 1'b1;
               state_d    = StWaitBusy;
            end
         end
         StWaitBusy: begin
            if (busy_tx) begin
               transmit_d = 1'b0;
               state_d    = StWaitDone;
            end
         end
         StWaitDone: begin
            if (!busy_tx) begin
               active_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: begin
            transmit_d = 1'b0;
            active_d   = 1'b0;
            state_d    = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         transmit_q <= 1'b0;
         data_tx_q  <= '0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         transmit_q <= transmit_d;
         data_tx_q  <= data_tx_d;
         active_q   <= active_d;
      end
   end

   // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign transmit = transmit_q;
   assign data_tx  = data_tx_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a byte-queue model predicts launches, occupancy and
// overflow; a monitor compares every cycle; a small UART model answers the handshake.
module tb_uart_tx_fifo;

   localparam int unsigned AW = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          nRst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          flush;
   logic          busy_tx;
   logic          transmit;
   logic [7:0]    data_tx;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          active;

   logic          uart_busy;
   logic          hold_busy;
   int            uart_len;
   int            checks = 0;
   int            failures = 0;
   int            launches = 0;
   logic [7:0]    exp_q [$];
   logic          exp_ovf;

   assign busy_tx = uart_busy | hold_busy;

   uart_tx_fifo #(.ADDR_W(AW)) dut (
      .clk      (clk),
      .nRst     (nRst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .flush    (flush),
      .busy_tx  (busy_tx),
      .transmit (transmit),
      .data_tx  (data_tx),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .active   (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
      end
   endtask

   // Inputs change and the model updates at +2 after each edge; the monitor samples at +1.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_cycle(input logic we, input logic [7:0] d, input logic fl);
      wr_en   = we;
      wr_data = d;
      flush   = fl;
      if (nRst) begin
         if (fl) begin
            exp_q.delete();
         end else if (we) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
         end
      end
      tick();
      wr_en = 1'b0;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (!(empty && !active && !transmit) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", int'(n < budget), 1);
      chk("drain_model_empty", exp_q.size(), 0);
   endtask

   // UART model: raises busy one cycle after seeing transmit, holds it uart_len cycles.
   initial begin
      int ust;
      int ucnt;
      uart_busy = 1'b0;
      ust = 0;
      ucnt = 0;
      forever begin
         @(posedge clk);
         #3;
         if (!nRst) begin
            ust = 0;
            uart_busy = 1'b0;
         end else begin
            case (ust)
               0: if (transmit) ust = 1;
               1: begin
                  uart_busy = 1'b1;
                  ucnt = uart_len;
                  ust = 2;
               end
               default: begin
                  ucnt--;
                  if (ucnt <= 0) begin
                     uart_busy = 1'b0;
                     ust = 0;
                  end
               end
            endcase
         end
      end
   end

   // Monitor: pops the model queue on each launch and checks status against model occupancy.
   initial begin
      logic       prev_tx;
      logic       prev_act;
      logic [7:0] launched;
      logic [7:0] exp_b;
      prev_tx = 1'b0;
      prev_act = 1'b0;
      launched = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!nRst) begin
            chk("rst_transmit", transmit, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_active", active, 0);
            chk("rst_data_tx", data_tx, 0);
            prev_tx = 1'b0;
            prev_act = 1'b0;
            exp_ovf = 1'b0;
         end else begin
            chk("overflow", overflow, exp_ovf);
            exp_ovf = 1'b0;
            if (transmit && !prev_tx) begin
               launches++;
               chk("launch_overlap", prev_act, 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_launch: data_tx=0x%0h while model queue is empty at %0t",
                           data_tx, $time);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk("data_tx", data_tx, exp_b);
               end
               launched = data_tx;
            end else if (transmit) begin
               chk("data_tx_stable", data_tx, launched);
            end
            if (transmit) chk("transmit_active", active, 1);
            chk("count", count, exp_q.size());
            chk("empty", empty, int'(exp_q.size() == 0));
            chk("full", full, int'(exp_q.size() == DEPTH));
            prev_tx = transmit;
            prev_act = active;
         end
      end
   end

   initial begin
      int n;
      int base;
      logic prev_b;
      nRst = 1'b0;
      wr_en = 1'b0;
      wr_data = '0;
      flush = 1'b0;
      hold_busy = 1'b0;
      uart_len = 8;
      exp_ovf = 1'b0;

      // Reset held with writes toggling: nothing may be queued.
      for (int i = 0; i < 8; i++) drive_cycle(logic'(i % 2), 8'($urandom), 1'b0);
      nRst = 1'b1;
      tick();

      // Single byte with exact handshake timing.
      drive_cycle(1'b1, 8'hA5, 1'b0);
      chk("single_tx_after_write", transmit, 0);
      tick();
      chk("single_tx_rise", transmit, 1);
      chk("single_data", data_tx, 8'hA5);
      chk("single_active", active, 1);
      tick();
      chk("single_tx_hold", transmit, 1);
      tick();
      chk("single_tx_fall", transmit, 0);
      chk("single_active_hold", active, 1);
      chk("single_count", count, 0);
      n = 0;
      while (busy_tx && n < 50) begin
         chk("single_active_while_busy", active, 1);
         tick();
         n++;
      end
      chk("single_busy_released", busy_tx, 0);
      chk("single_active_fall", active, 0);
      wait_drain(20);

      // Burst of 16 with a slow UART: order preserved, count peaks at 15.
      uart_len = 100;
      for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(i), 1'b0);
      chk("burst_count_peak", count, 15);
      chk("burst_full", full, 0);
      wait_drain(2500);

      // Overflow while the line is held busy.
      uart_len = 3;
      hold_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         drive_cycle(1'b1, 8'(8'h10 + i), 1'b0);
         if (i == 15) begin
            chk("ovf_full", full, 1);
            chk("ovf_count16", count, 16);
         end
      end
      chk("ovf_pulse", overflow, 1);
      chk("ovf_count_kept", count, 16);
      tick();
      chk("ovf_pulse_single", overflow, 0);
      hold_busy = 1'b0;
      wait_drain(400);

      // Same-cycle write and pop keep count at 8 across pointer wraps.
      uart_len = 2;
      hold_busy = 1'b1;
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
      hold_busy = 1'b0;
      drive_cycle(1'b1, 8'($urandom), 1'b0);
      n = 1;
      base = 0;
      prev_b = 1'b0;
      while (n < 40 && base < 1000) begin
         chk("wrap_count", count, 8);
         if (prev_b && !busy_tx) begin
            prev_b = busy_tx;
            drive_cycle(1'b1, 8'($urandom), 1'b0);
            n++;
         end else begin
            prev_b = busy_tx;
            tick();
         end
         base++;
      end
      chk("wrap_writes_done", n, 40);
      wait_drain(200);

      // Flush while the first of five bytes is on the line.
      uart_len = 20;
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
      n = 0;
      while (!busy_tx && n < 50) begin
         tick();
         n++;
      end
      chk("flush_saw_busy", busy_tx, 1);
      base = launches;
      drive_cycle(1'b0, 8'h00, 1'b1);
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_inflight_active", active, 1);
      wait_drain(100);
      repeat (10) tick();
      chk("flush_no_more_launches", launches, base);

      // Reset pulse during the launch handshake, then a clean byte.
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
      n = 0;
      while (!transmit && n < 50) begin
         tick();
         n++;
      end
      chk("rst_mid_saw_transmit", transmit, 1);
      nRst = 1'b0;
      exp_q.delete();
      exp_ovf = 1'b0;
      #1;
      chk("rst_mid_transmit", transmit, 0);
      chk("rst_mid_count", count, 0);
      chk("rst_mid_empty", empty, 1);
      chk("rst_mid_active", active, 0);
      tick();
      tick();
      nRst = 1'b1;
      tick();
      base = launches;
      drive_cycle(1'b1, 8'h3C, 1'b0);
      wait_drain(100);
      chk("rst_mid_next_launch", launches, base + 1);

      // Randomized traffic with flushes and external busy holds.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 4) hold_busy = ~hold_busy;
         uart_len = int'($urandom_range(1, 6));
         drive_cycle(logic'($urandom_range(0, 99) < 60), 8'($urandom),
                     logic'($urandom_range(0, 63) == 0));
      end
      hold_busy = 1'b0;
      wait_drain(300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
